// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared types and default widths for the product accumulator.
//   prod_acc_state_t : accumulator FSM state (IDLE, ACCUM, HOLD)
//   PROD_W           : default product width (multiplier output width)
//   ACC_W_DEF        : default accumulator / result width
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } prod_acc_state_t;

  localparam int PROD_W    = 10;
  localparam int ACC_W_DEF = 16;

endpackage

// File: rtl/prod_acc_add.sv
// prod_acc_add: ACC_W-bit unsigned adder with carry-out.
// Configuration macro: PROD_ACC_SAT_EN
//   defined     -> result clamps to all-ones whenever the addition carries out
//   not defined -> result wraps modulo 2^ACC_W
// Ports:
//   a     in  ACC_W  running accumulator value
//   b     in  ACC_W  zero-extended product
//   sum   out ACC_W  addition result (wrapped or saturated)
//   carry out 1      carry out of bit ACC_W-1 (raw, before saturation)
module prod_acc_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[ACC_W];

`ifdef PROD_ACC_SAT_EN
  // Once clamped, any further non-zero add carries again, so the value
  // stays pinned at all-ones for the rest of the group.
  assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums TERMS unsigned products per group and presents the
// registered sum plus a sticky overflow flag on an output handshake.
// Configuration macro: PROD_ACC_SAT_EN (saturating adds, see prod_acc_add).
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid and its payload stay stable until that transfer, except
// that clear or reset may drop out_valid.
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      synchronous active-low reset
//   clear      in  1      synchronous abort of partial sum and held result
//   in_valid   in  1      in_prod valid
//   in_prod    in  IN_W   unsigned product
//   in_ready   out 1      product can be accepted (not HOLD, not in reset)
//   out_valid  out 1      out_sum/out_ovf valid (state HOLD)
//   out_ready  in  1      downstream accepts result
//   out_sum    out ACC_W  group sum
//   out_ovf    out 1      carry occurred somewhere in the group
//   busy       out 1      state != IDLE
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int IN_W  = PROD_W,
  parameter int ACC_W = ACC_W_DEF,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_prod,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [7:0] LAST_IDX = 8'(TERMS - 1);

  prod_acc_state_t state, state_next;

  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic             sticky;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             last;

  assign in_ready  = (state != HOLD) && rst_n;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = (count == LAST_IDX);

  prod_acc_add #(.ACC_W(ACC_W)) u_add (
    .a     (acc),
    .b     (ACC_W'(in_prod)),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) state_next = last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // clear overrides both the accept path and the output handshake
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      sticky  <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_next;
      if (clear) begin
        // a product accepted this cycle is deliberately dropped
        acc    <= '0;
        count  <= '0;
        sticky <= 1'b0;
      end else if (accept) begin
        if (last) begin
          out_sum <= add_sum;
          out_ovf <= sticky | add_carry;
          acc     <= '0;
          count   <= '0;
          sticky  <= 1'b0;
        end else begin
          acc    <= add_sum;
          count  <= count + 8'd1;
          sticky <= sticky | add_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
module tb_prod_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;

  // instance A: TERMS = 4, ACC_W = 16
  logic        a_in_valid;
  logic [9:0]  a_in_prod;
  logic        a_in_ready;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [15:0] a_out_sum;
  logic        a_out_ovf;
  logic        a_busy;

  // instance B: TERMS = 8, ACC_W = 10 (overflow case)
  logic        b_in_valid;
  logic [9:0]  b_in_prod;
  logic        b_in_ready;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [9:0]  b_out_sum;
  logic        b_out_ovf;
  logic        b_busy;

  int n_checks;
  int n_err;

  prod_accumulator #(.IN_W(10), .ACC_W(16), .TERMS(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (a_in_valid),
    .in_prod   (a_in_prod),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_ovf   (a_out_ovf),
    .busy      (a_busy)
  );

  prod_accumulator #(.IN_W(10), .ACC_W(10), .TERMS(8)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (b_in_valid),
    .in_prod   (b_in_prod),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_ovf   (b_out_ovf),
    .busy      (b_busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [9:0] p);
    a_in_valid = 1'b1;
    a_in_prod  = p;
    step();
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_prod   = '0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in_prod   = '0;
    b_out_ready = 1'b1;

    // reset state
    step();
    step();
    check("rst_in_ready",  32'(a_in_ready), 0);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_sum",   32'(a_out_sum), 0);
    check("rst_out_ovf",   32'(a_out_ovf), 0);
    check("rst_busy",      32'(a_busy), 0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready",  32'(a_in_ready), 1);

    // basic group: 4 x 225 = 900
    send_a(10'd225);
    check("basic_busy1", 32'(a_busy), 1);
    send_a(10'd225);
    send_a(10'd225);
    check("basic_nvalid3", 32'(a_out_valid), 0);
    send_a(10'd225);
    check("basic_valid", 32'(a_out_valid), 1);
    check("basic_sum",   32'(a_out_sum), 900);
    check("basic_ovf",   32'(a_out_ovf), 0);

    // backpressure: 5 cycles of out_ready=0 with a pending input
    a_in_valid = 1'b1;
    a_in_prod  = 10'd7;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(a_in_ready), 0);
      step();
      check("bp_valid", 32'(a_out_valid), 1);
      check("bp_sum",   32'(a_out_sum), 900);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    check("bp_drop_valid", 32'(a_out_valid), 0);
    check("bp_idle",       32'(a_busy), 0);
    // next group must start from zero: 5+6+7+8 = 26
    send_a(10'd5);
    send_a(10'd6);
    send_a(10'd7);
    send_a(10'd8);
    a_in_valid = 1'b0;
    check("bp_next_valid", 32'(a_out_valid), 1);
    check("bp_next_sum",   32'(a_out_sum), 26);
    step();
    check("bp_next_done", 32'(a_out_valid), 0);

    // clear mid-group, with a product presented in the clear cycle
    send_a(10'd100);
    send_a(10'd100);
    clear = 1'b1;
    check("clr_in_ready", 32'(a_in_ready), 1);
    send_a(10'd100);
    clear = 1'b0;
    check("clr_idle", 32'(a_busy), 0);
    for (int i = 0; i < 4; i++) send_a(10'd1);
    a_in_valid = 1'b0;
    check("clr_valid", 32'(a_out_valid), 1);
    check("clr_sum",   32'(a_out_sum), 4);
    step();

    // clear while holding a result drops out_valid without a handshake
    for (int i = 0; i < 4; i++) send_a(10'd3);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    check("clrh_valid", 32'(a_out_valid), 1);
    check("clrh_sum",   32'(a_out_sum), 12);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clrh_drop", 32'(a_out_valid), 0);
    check("clrh_busy", 32'(a_busy), 0);
    a_out_ready = 1'b1;

    // bubbles: valid pattern 1,0,0,1,0,1,1 carrying 1,2,3,4
    send_a(10'd1);
    a_in_valid = 1'b0; step();
    step();
    send_a(10'd2);
    a_in_valid = 1'b0; step();
    send_a(10'd3);
    check("bub_nvalid", 32'(a_out_valid), 0);
    send_a(10'd4);
    a_in_valid = 1'b0;
    check("bub_valid", 32'(a_out_valid), 1);
    check("bub_sum",   32'(a_out_sum), 10);
    step();

    // reset while holding a result
    for (int i = 0; i < 4; i++) send_a(10'd2);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    check("rsth_valid", 32'(a_out_valid), 1);
    check("rsth_sum",   32'(a_out_sum), 8);
    rst_n = 1'b0;
    step();
    check("rsth_out_valid", 32'(a_out_valid), 0);
    check("rsth_out_sum",   32'(a_out_sum), 0);
    check("rsth_out_ovf",   32'(a_out_ovf), 0);
    check("rsth_busy",      32'(a_busy), 0);
    check("rsth_in_ready",  32'(a_in_ready), 0);
    rst_n = 1'b1;
    step();
    check("rsth_rel_ready", 32'(a_in_ready), 1);
    check("rsth_no_pulse",  32'(a_out_valid), 0);
    a_out_ready = 1'b1;

    // overflow on instance B: 8 x 225 = 1800 -> wraps to 776 or clamps to 1023
    b_in_valid = 1'b1;
    b_in_prod  = 10'd225;
    for (int i = 0; i < 7; i++) step();
    check("ovf_nvalid7", 32'(b_out_valid), 0);
    step();
    b_in_valid = 1'b0;
    check("ovf_valid", 32'(b_out_valid), 1);
`ifdef PROD_ACC_SAT_EN
    check("ovf_sum", 32'(b_out_sum), 1023);
`else
    check("ovf_sum", 32'(b_out_sum), 776);
`endif
    check("ovf_flag", 32'(b_out_ovf), 1);
    step();
    check("ovf_done", 32'(b_out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
